// File: rtl/ysyx_22050710_bru_pkg.sv
// Shared definitions for the predicting branch unit: branch function codes,
// 2-bit direction counter states and the saturating counter step.
package ysyx_22050710_bru_pkg;

    localparam logic [2:0] BR_JAL  = 3'b000;
    localparam logic [2:0] BR_JALR = 3'b001;
    localparam logic [2:0] BR_BEQ  = 3'b010;
    localparam logic [2:0] BR_BNE  = 3'b011;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_sat_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        else
            return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/ysyx_22050710_btb.sv
// Direct-mapped BTB storage: valid/ctr with async reset, tag/target without,
// two combinational read ports, one write port; flush clears valids and wins.
module ysyx_22050710_btb
    import ysyx_22050710_bru_pkg::*;
#(
    parameter int PC_WD   = 64,
    parameter int ENTRIES = 16,
    localparam int IDX_WD = $clog2(ENTRIES),
    localparam int TAG_WD = PC_WD - 2 - IDX_WD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [IDX_WD-1:0] rd_idx,
    output logic              rd_valid,
    output logic [TAG_WD-1:0] rd_tag,
    output logic [PC_WD-1:0]  rd_target,
    output logic [1:0]        rd_ctr,
    input  logic [IDX_WD-1:0] chk_idx,
    output logic              chk_valid,
    output logic [TAG_WD-1:0] chk_tag,
    output logic [1:0]        chk_ctr,
    input  logic              wr_en,
    input  logic [IDX_WD-1:0] wr_idx,
    input  logic [TAG_WD-1:0] wr_tag,
    input  logic              wr_target_en,
    input  logic [PC_WD-1:0]  wr_target,
    input  logic [1:0]        wr_ctr
);

    logic [ENTRIES-1:0] valid_vec;
    logic [1:0]         ctr_vec    [ENTRIES];
    logic [TAG_WD-1:0]  tag_mem    [ENTRIES];
    logic [PC_WD-1:0]   target_mem [ENTRIES];

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic       valid_reg;
        logic [1:0] ctr_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg <= 1'b0;
                ctr_reg   <= CTR_WNT;
            end else if (flush) begin
                valid_reg <= 1'b0;
            end else if (wr_en && wr_idx == IDX_WD'(gi)) begin
                valid_reg <= 1'b1;
                ctr_reg   <= wr_ctr;
            end
        end

        assign valid_vec[gi] = valid_reg;
        assign ctr_vec[gi]   = ctr_reg;
    end

    // Tag/target are don't-care while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            tag_mem[wr_idx] <= wr_tag;
            if (wr_target_en)
                target_mem[wr_idx] <= wr_target;
        end
    end

    assign rd_valid  = valid_vec[rd_idx];
    assign rd_tag    = tag_mem[rd_idx];
    assign rd_target = target_mem[rd_idx];
    assign rd_ctr    = ctr_vec[rd_idx];

    assign chk_valid = valid_vec[chk_idx];
    assign chk_tag   = tag_mem[chk_idx];
    assign chk_ctr   = ctr_vec[chk_idx];

endmodule

// File: rtl/ysyx_22050710_bru_pred.sv
// Branch unit with BTB prediction: IF lookup, ID resolution/redirect, BTB update.
// Optional perf counters enabled by defining YSYX_22050710_BRU_PERF_EN.
module ysyx_22050710_bru_pred
    import ysyx_22050710_bru_pkg::*;
#(
    parameter int PC_WD       = 64,
    parameter int GPR_WD      = 64,
    parameter int IMM_WD      = 64,
    parameter int BTB_ENTRIES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [PC_WD-1:0]  i_if_pc,
    output logic              o_pred_taken,
    output logic [PC_WD-1:0]  o_pred_target,
    input  logic              i_id_valid,
    input  logic [PC_WD-1:0]  i_pc,
    input  logic [GPR_WD-1:0] i_rs1data,
    input  logic [GPR_WD-1:0] i_rs2data,
    input  logic [IMM_WD-1:0] i_imm,
    input  logic              i_bren,
    input  logic [2:0]        i_brfunc,
    input  logic              i_pred_taken,
    input  logic [PC_WD-1:0]  i_pred_target,
    input  logic              i_ep_sel,
    input  logic [PC_WD-1:0]  i_epnpc,
    input  logic              i_btb_flush,
    output logic              o_redirect,
    output logic [PC_WD-1:0]  o_redirect_pc
`ifdef YSYX_22050710_BRU_PERF_EN
    ,
    output logic [63:0]       o_perf_br,
    output logic [63:0]       o_perf_miss
`endif
);

    localparam int IDX_WD = $clog2(BTB_ENTRIES);
    localparam int TAG_WD = PC_WD - 2 - IDX_WD;

    logic              rd_valid, chk_valid;
    logic [TAG_WD-1:0] rd_tag, chk_tag;
    logic [PC_WD-1:0]  rd_target;
    logic [1:0]        rd_ctr, chk_ctr;
    logic              if_hit, upd_hit;

    logic [PC_WD-1:0]  imm_ext, rs1_pc, jalr_sum, br_target;
    logic              cmp_eq, cmp_lt, cmp_ltu, taken_raw, act_taken, is_jump;
    logic              mispredict, upd_req, wr_en;
    logic [1:0]        wr_ctr;

    ysyx_22050710_btb #(
        .PC_WD   (PC_WD),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (i_clk),
        .rst          (i_rst),
        .flush        (i_btb_flush),
        .rd_idx       (i_if_pc[IDX_WD+1:2]),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_target    (rd_target),
        .rd_ctr       (rd_ctr),
        .chk_idx      (i_pc[IDX_WD+1:2]),
        .chk_valid    (chk_valid),
        .chk_tag      (chk_tag),
        .chk_ctr      (chk_ctr),
        .wr_en        (wr_en),
        .wr_idx       (i_pc[IDX_WD+1:2]),
        .wr_tag       (i_pc[PC_WD-1:IDX_WD+2]),
        .wr_target_en (act_taken),
        .wr_target    (br_target),
        .wr_ctr       (wr_ctr)
    );

    assign if_hit        = rd_valid && (rd_tag == i_if_pc[PC_WD-1:IDX_WD+2]);
    assign o_pred_taken  = if_hit && rd_ctr[1];
    assign o_pred_target = o_pred_taken ? rd_target : i_if_pc + PC_WD'(4);

    assign imm_ext  = PC_WD'($signed(i_imm));
    assign rs1_pc   = PC_WD'(i_rs1data);
    assign jalr_sum = rs1_pc + imm_ext;

    assign cmp_eq  = (i_rs1data == i_rs2data);
    assign cmp_lt  = ($signed(i_rs1data) < $signed(i_rs2data));
    assign cmp_ltu = (i_rs1data < i_rs2data);
    assign is_jump = (i_brfunc == BR_JAL) || (i_brfunc == BR_JALR);

    always_comb begin
        taken_raw = 1'b0;
        br_target = i_pc + imm_ext;
        case (i_brfunc)
            BR_JAL:  taken_raw = 1'b1;
            BR_JALR: begin
                taken_raw = 1'b1;
                br_target = {jalr_sum[PC_WD-1:1], 1'b0};
            end
            BR_BEQ:  taken_raw = cmp_eq;
            BR_BNE:  taken_raw = !cmp_eq;
            BR_BLT:  taken_raw = cmp_lt;
            BR_BGE:  taken_raw = !cmp_lt;
            BR_BLTU: taken_raw = cmp_ltu;
            BR_BGEU: taken_raw = !cmp_ltu;
            default: taken_raw = 1'b0;
        endcase
    end

    assign act_taken  = i_bren && taken_raw;
    assign mispredict = (act_taken != i_pred_taken) ||
                        (act_taken && (br_target != i_pred_target));
    assign o_redirect = i_id_valid && (i_ep_sel || (i_bren && mispredict));

    always_comb begin
        if (i_ep_sel)
            o_redirect_pc = i_epnpc;
        else if (act_taken)
            o_redirect_pc = br_target;
        else
            o_redirect_pc = i_pc + PC_WD'(4);
    end

    // Hits train the existing counter; misses allocate only when taken.
    assign upd_hit = chk_valid && (chk_tag == i_pc[PC_WD-1:IDX_WD+2]);
    assign upd_req = i_id_valid && i_bren && !i_ep_sel;
    assign wr_en   = upd_req && (upd_hit || act_taken);
    assign wr_ctr  = is_jump ? CTR_ST :
                     upd_hit ? ctr_sat_update(chk_ctr, act_taken) : CTR_WT;

`ifdef YSYX_22050710_BRU_PERF_EN
    logic [63:0] perf_br_reg, perf_miss_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            perf_br_reg   <= 64'd0;
            perf_miss_reg <= 64'd0;
        end else begin
            if (i_id_valid && i_bren)
                perf_br_reg <= perf_br_reg + 64'd1;
            if (i_id_valid && i_bren && !i_ep_sel && mispredict)
                perf_miss_reg <= perf_miss_reg + 64'd1;
        end
    end

    assign o_perf_br   = perf_br_reg;
    assign o_perf_miss = perf_miss_reg;
`endif

    logic unused_bits;
    assign unused_bits = ^{i_if_pc[1:0], i_pc[1:0], jalr_sum[0], rd_ctr[0]};

endmodule

// File: tb/tb_ysyx_22050710_bru_pred.sv
// Scoreboard bench for ysyx_22050710_bru_pred: stimulus pushes expected
// prediction/redirect values, a negedge monitor pops and compares them.
module tb_ysyx_22050710_bru_pred;

    localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MINNEG = 64'h8000_0000_0000_0000;
    localparam logic [2:0]  F_JAL  = 3'b000, F_JALR = 3'b001, F_BEQ = 3'b010, F_BNE = 3'b011;
    localparam logic [2:0]  F_BLT  = 3'b100, F_BGE  = 3'b101, F_BLTU = 3'b110, F_BGEU = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] i_if_pc;
    logic        o_pred_taken;
    logic [63:0] o_pred_target;
    logic        i_id_valid;
    logic [63:0] i_pc, i_rs1data, i_rs2data, i_imm;
    logic        i_bren;
    logic [2:0]  i_brfunc;
    logic        i_pred_taken;
    logic [63:0] i_pred_target;
    logic        i_ep_sel;
    logic [63:0] i_epnpc;
    logic        i_btb_flush;
    logic        o_redirect;
    logic [63:0] o_redirect_pc;
`ifdef YSYX_22050710_BRU_PERF_EN
    logic [63:0] o_perf_br, o_perf_miss;
`endif

    always #5 clk = ~clk;

    ysyx_22050710_bru_pred dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_if_pc       (i_if_pc),
        .o_pred_taken  (o_pred_taken),
        .o_pred_target (o_pred_target),
        .i_id_valid    (i_id_valid),
        .i_pc          (i_pc),
        .i_rs1data     (i_rs1data),
        .i_rs2data     (i_rs2data),
        .i_imm         (i_imm),
        .i_bren        (i_bren),
        .i_brfunc      (i_brfunc),
        .i_pred_taken  (i_pred_taken),
        .i_pred_target (i_pred_target),
        .i_ep_sel      (i_ep_sel),
        .i_epnpc       (i_epnpc),
        .i_btb_flush   (i_btb_flush),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc)
`ifdef YSYX_22050710_BRU_PERF_EN
        ,
        .o_perf_br     (o_perf_br),
        .o_perf_miss   (o_perf_miss)
`endif
    );

    typedef struct {
        string       name;
        bit          chk_pred;
        logic        exp_pt;
        logic [63:0] exp_ptgt;
        bit          chk_rd;
        logic        exp_rd;
        logic [63:0] exp_rpc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_id_valid   = 1'b0;
        i_bren       = 1'b0;
        i_ep_sel     = 1'b0;
        i_btb_flush  = 1'b0;
        i_pred_taken = 1'b0;
    endtask

    task automatic br(input logic [63:0] pc, input logic [63:0] rs1, input logic [63:0] rs2,
                      input logic [63:0] imm, input logic [2:0] f, input logic pt,
                      input logic [63:0] ptgt);
        i_id_valid    = 1'b1;
        i_bren        = 1'b1;
        i_ep_sel      = 1'b0;
        i_btb_flush   = 1'b0;
        i_pc          = pc;
        i_rs1data     = rs1;
        i_rs2data     = rs2;
        i_imm         = imm;
        i_brfunc      = f;
        i_pred_taken  = pt;
        i_pred_target = ptgt;
    endtask

    task automatic push(input string name, input bit cp, input logic pt, input logic [63:0] ptgt,
                        input bit cr, input logic rd, input logic [63:0] rpc);
        exp_t e;
        e.name = name; e.chk_pred = cp; e.exp_pt = pt; e.exp_ptgt = ptgt;
        e.chk_rd = cr; e.exp_rd = rd; e.exp_rpc = rpc;
        sb.push_back(e);
    endtask

    task automatic exp_both(input string name, input logic pt, input logic [63:0] ptgt,
                            input logic rd, input logic [63:0] rpc);
        push(name, 1'b1, pt, ptgt, 1'b1, rd, rpc);
    endtask

    task automatic exp_pred(input string name, input logic pt, input logic [63:0] ptgt);
        push(name, 1'b1, pt, ptgt, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic exp_rd(input string name, input logic rd, input logic [63:0] rpc);
        push(name, 1'b0, 1'b0, 64'd0, 1'b1, rd, rpc);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_pred) begin
                    n_tests++;
                    if (o_pred_taken !== e.exp_pt || o_pred_target !== e.exp_ptgt) begin
                        n_fail++;
                        $display("FAIL %s pred: got taken=%0b target=%h, expected taken=%0b target=%h",
                                 e.name, o_pred_taken, o_pred_target, e.exp_pt, e.exp_ptgt);
                    end
                end
                if (e.chk_rd) begin
                    n_tests++;
                    if (o_redirect !== e.exp_rd || (e.exp_rd && o_redirect_pc !== e.exp_rpc)) begin
                        n_fail++;
                        $display("FAIL %s redirect: got %0b pc=%h, expected %0b pc=%h",
                                 e.name, o_redirect, o_redirect_pc, e.exp_rd, e.exp_rpc);
                    end
                end
                $display("[TB] %s: pred=%0b/%h redirect=%0b/%h", e.name,
                         o_pred_taken, o_pred_target, o_redirect, o_redirect_pc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        i_if_pc = BASE;
        i_pc = 64'd0; i_rs1data = 64'd0; i_rs2data = 64'd0; i_imm = 64'd0;
        i_brfunc = F_JAL; i_pred_target = 64'd0; i_epnpc = 64'd0;
        idle();

        step();
        exp_both("reset", 1'b0, BASE + 64'd4, 1'b0, 64'd0);

        // Allocation, then counter 10->11->11->11->10->01.
        step(); rst = 1'b0;
        br(BASE, 64'd5, 64'd5, 64'h10, F_BEQ, 1'b0, 64'd0); i_if_pc = BASE;
        exp_both("beq_alloc", 1'b0, BASE + 64'd4, 1'b1, BASE + 64'h10);
        step(); idle();
        exp_pred("lookup_after_alloc", 1'b1, BASE + 64'h10);
        for (int k = 0; k < 3; k++) begin
            step(); br(BASE, 64'd5, 64'd5, 64'h10, F_BEQ, 1'b1, BASE + 64'h10);
            exp_both($sformatf("beq_taken_%0d", k), 1'b1, BASE + 64'h10, 1'b0, 64'd0);
        end
        step(); br(BASE, 64'd1, 64'd2, 64'h10, F_BEQ, 1'b1, BASE + 64'h10);
        exp_both("beq_nt_1", 1'b1, BASE + 64'h10, 1'b1, BASE + 64'd4);
        step(); br(BASE, 64'd1, 64'd2, 64'h10, F_BEQ, 1'b1, BASE + 64'h10);
        exp_both("beq_nt_2", 1'b1, BASE + 64'h10, 1'b1, BASE + 64'd4);
        step(); idle();
        exp_pred("beq_pred_nt", 1'b0, BASE + 64'd4);

        // Compare edge cases.
        step(); br(BASE + 64'h20, MINNEG, 64'd1, 64'h40, F_BLT, 1'b0, 64'd0);
        exp_rd("blt_minneg", 1'b1, BASE + 64'h60);
        step(); br(BASE + 64'h24, MINNEG, 64'd1, 64'h40, F_BLTU, 1'b0, 64'd0);
        exp_rd("bltu_minneg", 1'b0, 64'd0);
        step(); br(BASE + 64'h28, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, F_BGEU, 1'b0, 64'd0);
        exp_rd("bgeu_rs2_zero", 1'b1, BASE + 64'h20);
        step(); br(BASE + 64'h2C, MINNEG, 64'd1, 64'h10, F_BGE, 1'b0, 64'd0);
        exp_rd("bge_minneg", 1'b0, 64'd0);
        step(); br(BASE + 64'h2C, 64'd7, 64'd7, 64'h10, F_BNE, 1'b0, 64'd0);
        exp_rd("bne_equal", 1'b0, 64'd0);

        // Jumps.
        step(); br(BASE + 64'h30, 64'h8000_1003, 64'd0, 64'd0, F_JALR, 1'b1, 64'h8000_1002);
        exp_rd("jalr_correct", 1'b0, 64'd0);
        step(); idle(); i_if_pc = BASE + 64'h30;
        exp_pred("jalr_lookup", 1'b1, 64'h8000_1002);
        step(); br(BASE + 64'h34, 64'd0, 64'd0, 64'h100, F_JAL, 1'b0, 64'd0); i_if_pc = BASE;
        exp_rd("jal_mispred", 1'b1, BASE + 64'h134);

        // ep_sel priority and bubbles: redirect rules, no table writes.
        step(); br(BASE + 64'h38, 64'd3, 64'd3, 64'h10, F_BEQ, 1'b0, 64'd0);
        i_ep_sel = 1'b1; i_epnpc = BASE + 64'h200;
        exp_rd("ep_sel", 1'b1, BASE + 64'h200);
        step(); idle(); i_if_pc = BASE + 64'h38;
        exp_pred("ep_sel_no_write", 1'b0, BASE + 64'h3C);
        step(); br(BASE + 64'h3C, 64'd3, 64'd3, 64'h10, F_BEQ, 1'b0, 64'd0); i_id_valid = 1'b0;
        exp_rd("bubble", 1'b0, 64'd0);
        step(); idle(); i_if_pc = BASE + 64'h3C;
        exp_pred("bubble_no_write", 1'b0, BASE + 64'h40);

        // Update + flush together; same-index lookup sees old entry.
        step(); br(BASE + 64'h20, 64'd9, 64'd9, 64'h40, F_BEQ, 1'b1, BASE + 64'h60);
        i_btb_flush = 1'b1; i_if_pc = BASE + 64'h20;
        exp_both("update_flush", 1'b1, BASE + 64'h60, 1'b0, 64'd0);
        step(); idle(); i_if_pc = BASE + 64'h20;
        exp_pred("flushed_idx8", 1'b0, BASE + 64'h24);
        step(); i_if_pc = BASE + 64'h30;
        exp_pred("flushed_idx12", 1'b0, BASE + 64'h34);

        // Reallocate, then async reset mid-operation.
        step(); br(BASE + 64'h40, 64'd4, 64'd4, 64'h10, F_BEQ, 1'b0, 64'd0); i_if_pc = BASE + 64'h40;
        exp_both("realloc", 1'b0, BASE + 64'h44, 1'b1, BASE + 64'h50);
        step(); idle();
        exp_pred("realloc_lookup", 1'b1, BASE + 64'h50);
        step(); rst = 1'b1;
        exp_pred("async_reset", 1'b0, BASE + 64'h44);
        step(); rst = 1'b0;
        exp_pred("after_reset", 1'b0, BASE + 64'h44);

        step();
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_bru_pred.md
Name: ysyx_22050710_bru_pred

Overview:
Second-generation branch unit: resolves branches/jumps in ID and adds a direct-mapped BTB with 2-bit saturating direction counters, looked up by IF every cycle.
- ID compares its actual outcome against the prediction that travelled down with the instruction.
- On mismatch, or on ecall/mret, it raises a one-cycle redirect.
- Table state is updated at the clock edge of resolution.

Parameters:
PC_WD, 64, PC width
GPR_WD, 64, register operand width
IMM_WD, 64, immediate width; must be ≤ PC_WD, sign-extended to PC_WD internally
BTB_ENTRIES, 16, entries; power of two, ≥ 2; IDX_WD = log2(BTB_ENTRIES), TAG_WD = PC_WD-2-IDX_WD

Ports:
i_clk  in  1  clock; the block uses one clock, and reset is asynchronous, active-high
i_rst  in  1  asynchronous active-high reset
i_if_pc  in  PC_WD  fetch PC for lookup
o_pred_taken  out  1  predicted taken
o_pred_target  out  PC_WD  predicted target; i_if_pc+4 when not taken
i_id_valid  in  1  ID holds a valid instruction this cycle
i_pc  in  PC_WD  ID instruction PC
i_rs1data  in  GPR_WD  rs1 operand
i_rs2data  in  GPR_WD  rs2 operand
i_imm  in  IMM_WD  immediate
i_bren  in  1  instruction is branch/jump
i_brfunc  in  3  000 jal, 001 jalr, 010 beq, 011 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
i_pred_taken  in  1  prediction carried from IF
i_pred_target  in  PC_WD  predicted target carried from IF
i_ep_sel  in  1  ecall/mret redirect request
i_epnpc  in  PC_WD  exception/return target
i_btb_flush  in  1  invalidate all entries (fence.i)
o_redirect  out  1  flush and refetch
o_redirect_pc  out  PC_WD  refetch address

Behaviour:
- Reset, asynchronous:
  - all valid bits = 0; all counters = 2'b01 (weak not-taken); tags and targets don't-care.
  - Result: o_pred_taken=0, o_pred_target=i_if_pc+4, o_redirect=0.
- Lookup is combinational, zero latency:
  - idx = i_if_pc[IDX_WD+1:2], tag = i_if_pc[PC_WD-1:IDX_WD+2].
  - hit = valid[idx] & tag match.
  - o_pred_taken = hit & ctr[idx][1].
- Resolution is combinational in ID:
  - eq/lt/ltu use full-width signed and unsigned compares of rs1 and rs2 (correct for every operand pair, including rs2=0 and the most-negative value).
  - jal/jalr: always taken.
  - Target: jal/branch = i_pc+imm; jalr = (rs1+imm) with bit0 cleared. All sums are modulo 2^PC_WD.
- Redirect: o_redirect = i_id_valid & (i_ep_sel | (i_bren & mispredict)).
  - mispredict = (act_taken != i_pred_taken) | (act_taken & target != i_pred_target).
- o_redirect_pc priority:
  1. i_ep_sel → i_epnpc
  2. act_taken → target
  3. otherwise → i_pc+4
  - i_ep_sel also wins over i_bren when both are set.
- Update: at the rising edge when i_id_valid & i_bren & ~i_ep_sel, entry i_pc[IDX_WD+1:2] is written.
  - Hit, conditional branch: ctr ± 1, saturating at 00 and 11.
  - Hit, jal/jalr: ctr = 11.
  - Target field is rewritten whenever act_taken.
  - Miss and act_taken: allocate (overwrite); valid=1, tag, target, ctr = 10 (11 for jumps).
  - Miss and not taken: no write.
- Same-cycle lookup and update to the same index: lookup returns the pre-edge value (read-before-write).
- i_btb_flush: clears all valid bits at the edge. It wins over a simultaneous update; counters are kept.
- i_id_valid=0 (bubble/stall): no update and no redirect, regardless of other inputs.
- Reset asserted mid-operation: state clears immediately; the first edge after deassert performs normal updates.

Optional Feature:
- Macro YSYX_22050710_BRU_PERF_EN defined:
  - adds 64-bit outputs o_perf_br (counts resolved i_bren instructions when i_id_valid) and o_perf_miss (counts redirects caused by mispredict, excluding ep_sel).
  - Both reset to 0 and wrap modulo 2^64.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ysyx_22050710_bru_pkg:
  - brfunc encodings (BR_JAL..BR_BGEU)
  - counter localparams CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11
  - function for saturating counter update
- One sub-module ysyx_22050710_btb: valid/tag/target/ctr storage, combinational read port, single write port, flush.
- Compare and target logic stays in the top module.

Test Plan:
- Reset, then i_if_pc=0x80000000 → o_pred_taken=0, o_pred_target=0x80000004; beq at 0x80000000 with rs1=rs2=5, imm=0x10, pred 0 → o_redirect=1, o_redirect_pc=0x80000010; next cycle the same lookup gives taken, target 0x80000010.
- Same beq taken 3 more times, then rs1=1, rs2=2 twice: counter goes 10→11→11→11→10→01 → prediction is not taken after the second not-taken.
- blt with rs1=0x8000_0000_0000_0000, rs2=1 → taken; bltu with the same operands → not taken; bgeu with rs2=0 → always taken.
- jalr rs1=0x80001003, imm=0 → target 0x80001002; with correct prediction → o_redirect=0.
- i_ep_sel=1, i_bren=1, i_epnpc=0x80000200 → redirect to 0x80000200, no BTB write; i_id_valid=0 with a mispredict → o_redirect=0, no write.
- Update and i_btb_flush in the same cycle → all lookups miss afterwards; same-index lookup during the update cycle returns the old entry.
